csr_regfile: RTL and testbench

Control/status register file that consumes the write-back stage's CSR write port, exception report and ERTN flush, and supplies CSR read data to the decode/execute path. It also supplies the exception entry and return targets to fetch, plus a pending-interrupt flag to the stage that tags instructions with INT. It holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID, TCFG, TVAL and TICLR, and contains the constant timer.

---
 rtl/csr_regfile_pkg.sv | 46 ++++
 rtl/csr_regfile_if.sv | 35 +++
 rtl/csr_regfile_timer.sv | 37 +++
 rtl/csr_regfile.sv | 131 +++++++++++++
 tb/tb_csr_regfile.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_regfile_pkg.sv
// CSR numbers, field positions, exception codes and the TCFG layout
// shared by the CSR register file and its timer.
package csr_regfile_pkg;

  // CSR numbers
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // field positions / widths
  localparam int CRMD_W      = 5;   // PLV[1:0] IE[2] DA[3] PG[4]
  localparam int CRMD_IE     = 2;
  localparam int PRMD_W      = 3;   // PPLV[1:0] PIE[2]
  localparam int ESTAT_IS_W  = 13;
  localparam int EENTRY_VA   = 6;
  localparam int TICLR_CLR   = 0;

  // LIE bit 10 does not exist
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

  localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

  // exception codes that touch BADV
  localparam logic [5:0] ECODE_ADE     = 6'h08;
  localparam logic [5:0] ECODE_ALE     = 6'h09;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  typedef struct packed {
    logic [29:0] initval;
    logic        periodic;
    logic        en;
  } tcfg_t;

endpackage

// File: rtl/csr_regfile_if.sv
// Pipeline-facing CSR port: read/write port, write-back exception and
// ERTN report, interrupt lines and the fetch/tagging outputs.
interface csr_regfile_if;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rval;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wval;
  logic        wb_exc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        has_int;

  modport master (
    output csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
           wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    input  csr_rval, ex_entry, ertn_pc, has_int
  );

  modport slave (
    input  csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
           wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    output csr_rval, ex_entry, ertn_pc, has_int
  );
endinterface

// File: rtl/csr_regfile_timer.sv
// Constant timer: owns TCFG and TVAL, counts down and flags the cycle
// on which the timer interrupt must be raised.
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  tcfg_t       tcfg_new,
  output tcfg_t       tcfg,
  output logic [31:0] tval,
  output logic        timer_int_set
);
  logic zero;

  assign zero = (tval == 32'h0);
  // a TCFG write in the same cycle pre-empts both the fire and the decrement
  assign timer_int_set = ~tcfg_we & tcfg.en & zero;

  // TCFG register
  always_ff @(posedge clk) begin
    if (reset)        tcfg <= '0;
    else if (tcfg_we) tcfg <= tcfg_new;
  end

  // TVAL: load on enabling write, count down, reload or park at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      tval <= 32'h0;
    end else if (tcfg_we) begin
      if (tcfg_new.en) tval <= {tcfg_new.initval, 2'b00};
    end else if (tcfg.en) begin
      if (zero)                    tval <= tcfg.periodic ? {tcfg.initval, 2'b00} : 32'hFFFF_FFFF;
      else if (tval != 32'hFFFF_FFFF) tval <= tval - 32'd1;
    end
  end
endmodule

// File: rtl/csr_regfile.sv
// CSR register file: architectural CSRs, exception/ERTN side effects,
// interrupt pending logic and the constant timer.
module csr_regfile
  import csr_regfile_pkg::*;
(
  input logic          clk,
  input logic          reset,
  csr_regfile_if.slave bus
);
  logic [CRMD_W-1:0]     crmd;
  logic [PRMD_W-1:0]     prmd;
  logic [12:0]           ecfg;
  logic [1:0]            is_sw;
  logic [7:0]            is_hw;
  logic                  is_ti;
  logic                  is_ipi;
  logic [5:0]            ecode;
  logic [8:0]            esubcode;
  logic [31:0]           era, badv, tid;
  logic [31-EENTRY_VA:0] eentry_va;
  logic [3:0][31:0]      save;
  tcfg_t                 tcfg, tcfg_new;
  logic [31:0]           tval;
  logic                  timer_int_set;
  logic                  sw_we, tcfg_we, ticlr_clr;
  logic [31:0]           wm, wv, rval;
  logic [ESTAT_IS_W-1:0] estat_is;

  // software writes lose to any exception or ERTN in the same cycle
  assign sw_we     = bus.csr_we & ~bus.wb_exc & ~bus.ertn_flush;
  assign wm        = bus.csr_wmask;
  assign wv        = bus.csr_wval & bus.csr_wmask;
  assign tcfg_we   = sw_we & (bus.csr_wnum == CSR_TCFG);
  assign tcfg_new  = tcfg_t'((tcfg & ~wm) | wv);
  assign ticlr_clr = sw_we & (bus.csr_wnum == CSR_TICLR) & wv[TICLR_CLR];
  assign estat_is  = {is_ipi, is_ti, 1'b0, is_hw, is_sw};

  csr_timer u_timer (
    .clk           (clk),
    .reset         (reset),
    .tcfg_we       (tcfg_we),
    .tcfg_new      (tcfg_new),
    .tcfg          (tcfg),
    .tval          (tval),
    .timer_int_set (timer_int_set)
  );

  // architectural registers: exception > ERTN > software write
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd      <= CRMD_RESET[CRMD_W-1:0];
      prmd      <= '0;
      ecfg      <= '0;
      is_sw     <= '0;
      ecode     <= '0;
      esubcode  <= '0;
      era       <= '0;
      badv      <= '0;
      eentry_va <= '0;
      save      <= '0;
      tid       <= '0;
    end else if (bus.wb_exc) begin
      prmd      <= crmd[2:0];
      crmd[2:0] <= 3'b000;
      era       <= bus.wb_pc;
      ecode     <= bus.wb_ecode;
      esubcode  <= bus.wb_esubcode;
      if (bus.wb_ecode == ECODE_ADE && bus.wb_esubcode == ESUBCODE_ADEF) badv <= bus.wb_pc;
      else if (bus.wb_ecode == ECODE_ALE)                                badv <= bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      crmd[2:0] <= prmd;
    end else if (sw_we) begin
      case (bus.csr_wnum)
        CSR_CRMD:   crmd      <= (crmd & ~wm[CRMD_W-1:0]) | wv[CRMD_W-1:0];
        CSR_PRMD:   prmd      <= (prmd & ~wm[PRMD_W-1:0]) | wv[PRMD_W-1:0];
        CSR_ECFG:   ecfg      <= ((ecfg & ~wm[12:0]) | wv[12:0]) & ECFG_LIE_MASK;
        CSR_ESTAT:  is_sw     <= (is_sw & ~wm[1:0]) | wv[1:0];
        CSR_ERA:    era       <= (era & ~wm) | wv;
        CSR_BADV:   badv      <= (badv & ~wm) | wv;
        CSR_EENTRY: eentry_va <= (eentry_va & ~wm[31:EENTRY_VA]) | wv[31:EENTRY_VA];
        CSR_SAVE0:  save[0]   <= (save[0] & ~wm) | wv;
        CSR_SAVE1:  save[1]   <= (save[1] & ~wm) | wv;
        CSR_SAVE2:  save[2]   <= (save[2] & ~wm) | wv;
        CSR_SAVE3:  save[3]   <= (save[3] & ~wm) | wv;
        CSR_TID:    tid       <= (tid & ~wm) | wv;
        default: ;
      endcase
    end
  end

  // interrupt status: level lines sampled each cycle, timer bit sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      is_hw  <= '0;
      is_ipi <= 1'b0;
      is_ti  <= 1'b0;
    end else begin
      is_hw  <= bus.hw_int_in;
      is_ipi <= bus.ipi_int_in;
      if (timer_int_set)  is_ti <= 1'b1;
      else if (ticlr_clr) is_ti <= 1'b0;
    end
  end

  // read mux, no write bypass
  always_comb begin
    rval = '0;
    case (bus.csr_rnum)
      CSR_CRMD:   rval[CRMD_W-1:0] = crmd;
      CSR_PRMD:   rval[PRMD_W-1:0] = prmd;
      CSR_ECFG:   rval[12:0]       = ecfg;
      CSR_ESTAT:  rval             = {1'b0, esubcode, ecode, 3'b000, estat_is};
      CSR_ERA:    rval             = era;
      CSR_BADV:   rval             = badv;
      CSR_EENTRY: rval             = {eentry_va, 6'b0};
      CSR_SAVE0:  rval             = save[0];
      CSR_SAVE1:  rval             = save[1];
      CSR_SAVE2:  rval             = save[2];
      CSR_SAVE3:  rval             = save[3];
      CSR_TID:    rval             = tid;
      CSR_TCFG:   rval             = tcfg;
      CSR_TVAL:   rval             = tval;
      default: ;
    endcase
  end

  assign bus.csr_rval = rval;
  assign bus.ex_entry = {eentry_va, 6'b0};
  assign bus.ertn_pc  = era;
  assign bus.has_int  = crmd[CRMD_IE] & |(estat_is & ecfg);
endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios with constant
// expectations plus a randomized run against a word-level CSR model.
module tb_csr_regfile;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #50 clk = ~clk;

  csr_regfile_if bus();
  csr_regfile dut (.clk(clk), .reset(reset), .bus(bus));

  // reference model: each CSR as a full 32-bit word
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
  logic [31:0] m_save [4];

  logic [13:0] addrs [18] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31,
                              14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h43, 14'h3FFF};

  function automatic logic [31:0] wr_bits(input logic [13:0] a);
    case (a)
      14'h0:  return 32'h0000_001F;
      14'h1:  return 32'h0000_0007;
      14'h4:  return 32'h0000_1BFF;
      14'h5:  return 32'h0000_0003;
      14'hC:  return 32'hFFFF_FFC0;
      14'h6, 14'h7, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    case (a)
      14'h0:  return m_crmd;
      14'h1:  return m_prmd;
      14'h4:  return m_ecfg;
      14'h5:  return m_estat;
      14'h6:  return m_era;
      14'h7:  return m_badv;
      14'hC:  return m_eentry;
      14'h30: return m_save[0];
      14'h31: return m_save[1];
      14'h32: return m_save[2];
      14'h33: return m_save[3];
      14'h40: return m_tid;
      14'h41: return m_tcfg;
      14'h42: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    return m_crmd[2] && ((m_estat[12:0] & m_ecfg[12:0]) != 13'h0);
  endfunction

  // advance the model by one clock edge using the inputs presented this cycle
  task automatic model_step();
    logic [31:0] wmk, merged, n_tval, n_estat;
    logic sw, fire, clr;
    if (reset) begin
      m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
      m_eentry = 0; m_tid = 0; m_tcfg = 0; m_tval = 0;
      for (int i = 0; i < 4; i++) m_save[i] = 0;
      return;
    end
    sw     = bus.csr_we && !bus.wb_exc && !bus.ertn_flush;
    wmk    = bus.csr_wmask & wr_bits(bus.csr_wnum);
    merged = (m_read(bus.csr_wnum) & ~wmk) | (bus.csr_wval & wmk);
    fire   = 1'b0;
    n_tval = m_tval;
    if (sw && bus.csr_wnum == 14'h41) begin
      if (merged[0]) n_tval = merged & ~32'h3;
    end else if (m_tcfg[0]) begin
      if (m_tval == 0) begin
        fire   = 1'b1;
        n_tval = m_tcfg[1] ? (m_tcfg & ~32'h3) : 32'hFFFF_FFFF;
      end else if (m_tval != 32'hFFFF_FFFF) n_tval = m_tval - 1;
    end
    clr = sw && bus.csr_wnum == 14'h44 && bus.csr_wmask[0] && bus.csr_wval[0];
    n_estat = m_estat;
    if (bus.wb_exc) begin
      n_estat[21:16] = bus.wb_ecode;
      n_estat[30:22] = bus.wb_esubcode;
      m_prmd = m_crmd & 32'h7;
      m_crmd = m_crmd & ~32'h7;
      m_era  = bus.wb_pc;
      if (bus.wb_ecode == 6'h8 && bus.wb_esubcode == 9'h0) m_badv = bus.wb_pc;
      else if (bus.wb_ecode == 6'h9) m_badv = bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      m_crmd = (m_crmd & ~32'h7) | m_prmd;
    end else if (sw) begin
      case (bus.csr_wnum)
        14'h0:  m_crmd = merged;
        14'h1:  m_prmd = merged;
        14'h4:  m_ecfg = merged;
        14'h5:  n_estat = merged;
        14'h6:  m_era = merged;
        14'h7:  m_badv = merged;
        14'hC:  m_eentry = merged;
        14'h30: m_save[0] = merged;
        14'h31: m_save[1] = merged;
        14'h32: m_save[2] = merged;
        14'h33: m_save[3] = merged;
        14'h40: m_tid = merged;
        14'h41: m_tcfg = merged;
        default: ;
      endcase
    end
    n_estat[9:2] = bus.hw_int_in;
    n_estat[12]  = bus.ipi_int_in;
    n_estat[11]  = fire ? 1'b1 : (clr ? 1'b0 : m_estat[11]);
    m_estat = n_estat;
    m_tval  = n_tval;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.csr_rnum = 0; bus.csr_we = 0; bus.csr_wnum = 0; bus.csr_wmask = 0; bus.csr_wval = 0;
    bus.wb_exc = 0; bus.wb_ecode = 0; bus.wb_esubcode = 0; bus.wb_pc = 0; bus.wb_vaddr = 0;
    bus.ertn_flush = 0; bus.hw_int_in = 0; bus.ipi_int_in = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a);
    bus.csr_rnum = a;
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] v, input logic [31:0] m);
    bus.csr_we = 1'b1; bus.csr_wnum = a; bus.csr_wval = v; bus.csr_wmask = m;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd(14'h0);
    total++; if (bus.csr_rval !== 32'h8) begin bad++; $display("FAIL reset_crmd got=%h exp=%h", bus.csr_rval, 32'h8); end
    rd(14'h5);
    total++; if (bus.csr_rval !== 32'h0) begin bad++; $display("FAIL reset_estat got=%h exp=0", bus.csr_rval); end
    total++; if (bus.has_int !== 1'b0) begin bad++; $display("FAIL reset_has_int got=%b exp=0", bus.has_int); end
    total++; if (bus.ex_entry !== 32'h0) begin bad++; $display("FAIL reset_ex_entry got=%h exp=0", bus.ex_entry); end
    total++; if (bus.ertn_pc !== 32'h0) begin bad++; $display("FAIL reset_ertn_pc got=%h exp=0", bus.ertn_pc); end
    for (int i = 0; i < 18; i++) begin
      rd(addrs[i]);
      total++;
      if (bus.csr_rval !== ((addrs[i] == 14'h0) ? 32'h8 : 32'h0)) begin
        bad++; $display("FAIL reset_read addr=%h got=%h", addrs[i], bus.csr_rval);
      end
    end
  endtask

  task automatic test_masked_write();
    do_reset();
    wr(14'h31, 32'h1234_5678, 32'hFFFF_FFFF);
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h31; bus.csr_wval = 32'hDEAD_BEEF; bus.csr_wmask = 32'hFFFF_0000;
    rd(14'h31);
    total++; if (bus.csr_rval !== 32'h1234_5678) begin bad++; $display("FAIL no_bypass got=%h exp=%h", bus.csr_rval, 32'h1234_5678); end
    tick();
    bus.csr_we = 1'b0;
    rd(14'h31);
    total++; if (bus.csr_rval !== 32'hDEAD_5678) begin bad++; $display("FAIL masked_save1 got=%h exp=%h", bus.csr_rval, 32'hDEAD_5678); end
    wr(14'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(14'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(14'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(14'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(14'h42, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h0);
    total++; if (bus.csr_rval !== 32'h1F) begin bad++; $display("FAIL crmd_fields got=%h exp=1f", bus.csr_rval); end
    rd(14'h4);
    total++; if (bus.csr_rval !== 32'h1BFF) begin bad++; $display("FAIL ecfg_bit10 got=%h exp=1bff", bus.csr_rval); end
    rd(14'h5);
    total++; if (bus.csr_rval !== 32'h3) begin bad++; $display("FAIL estat_sw_bits got=%h exp=3", bus.csr_rval); end
    rd(14'hC);
    total++; if (bus.csr_rval !== 32'hFFFF_FFC0) begin bad++; $display("FAIL eentry_low got=%h exp=ffffffc0", bus.csr_rval); end
    total++; if (bus.ex_entry !== 32'hFFFF_FFC0) begin bad++; $display("FAIL ex_entry got=%h exp=ffffffc0", bus.ex_entry); end
    rd(14'h42);
    total++; if (bus.csr_rval !== 32'h0) begin bad++; $display("FAIL tval_ro got=%h exp=0", bus.csr_rval); end
  endtask

  task automatic test_exception();
    do_reset();
    wr(14'h0, 32'h7, 32'h7);
    bus.wb_exc = 1'b1; bus.wb_ecode = 6'hB; bus.wb_esubcode = 9'h0; bus.wb_pc = 32'h1C00_0100;
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h30; bus.csr_wval = 32'h55; bus.csr_wmask = 32'hFFFF_FFFF;
    tick();
    idle();
    rd(14'h1);
    total++; if (bus.csr_rval !== 32'h7) begin bad++; $display("FAIL exc_prmd got=%h exp=7", bus.csr_rval); end
    rd(14'h0);
    total++; if (bus.csr_rval !== 32'h8) begin bad++; $display("FAIL exc_crmd got=%h exp=8", bus.csr_rval); end
    rd(14'h6);
    total++; if (bus.csr_rval !== 32'h1C00_0100) begin bad++; $display("FAIL exc_era got=%h exp=1c000100", bus.csr_rval); end
    total++; if (bus.ertn_pc !== 32'h1C00_0100) begin bad++; $display("FAIL exc_ertn_pc got=%h exp=1c000100", bus.ertn_pc); end
    rd(14'h5);
    total++; if (bus.csr_rval[21:16] !== 6'hB) begin bad++; $display("FAIL exc_ecode got=%h exp=b", bus.csr_rval[21:16]); end
    rd(14'h30);
    total++; if (bus.csr_rval !== 32'h0) begin bad++; $display("FAIL exc_beats_we got=%h exp=0", bus.csr_rval); end
    rd(14'h7);
    total++; if (bus.csr_rval !== 32'h0) begin bad++; $display("FAIL sys_badv got=%h exp=0", bus.csr_rval); end
    bus.ertn_flush = 1'b1;
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h0; bus.csr_wval = 32'h0; bus.csr_wmask = 32'hFFFF_FFFF;
    tick();
    idle();
    rd(14'h0);
    total++; if (bus.csr_rval !== 32'hF) begin bad++; $display("FAIL ertn_crmd got=%h exp=f", bus.csr_rval); end
  endtask

  task automatic test_badv();
    do_reset();
    bus.wb_exc = 1'b1; bus.wb_ecode = 6'h8; bus.wb_esubcode = 9'h0; bus.wb_pc = 32'h1C00_0002; bus.wb_vaddr = 32'hABCD;
    tick();
    rd(14'h7);
    total++; if (bus.csr_rval !== 32'h1C00_0002) begin bad++; $display("FAIL badv_adef got=%h exp=1c000002", bus.csr_rval); end
    bus.wb_ecode = 6'h9; bus.wb_pc = 32'h1C00_0010; bus.wb_vaddr = 32'h0000_1003;
    tick();
    rd(14'h7);
    total++; if (bus.csr_rval !== 32'h0000_1003) begin bad++; $display("FAIL badv_ale got=%h exp=1003", bus.csr_rval); end
    bus.wb_ecode = 6'h8; bus.wb_esubcode = 9'h1; bus.wb_pc = 32'h1C00_0020;
    tick();
    idle();
    rd(14'h7);
    total++; if (bus.csr_rval !== 32'h0000_1003) begin bad++; $display("FAIL badv_adem got=%h exp=1003", bus.csr_rval); end
    rd(14'h5);
    total++; if (bus.csr_rval[30:22] !== 9'h1) begin bad++; $display("FAIL esubcode got=%h exp=1", bus.csr_rval[30:22]); end
  endtask

  task automatic test_timer_oneshot();
    do_reset();
    wr(14'h4, 32'h800, 32'hFFFF_FFFF);
    wr(14'h0, 32'h4, 32'h4);
    wr(14'h41, 32'h11, 32'hFFFF_FFFF);
    for (int k = 16; k >= 0; k--) begin
      rd(14'h42);
      total++; if (bus.csr_rval !== 32'(k)) begin bad++; $display("FAIL oneshot_tval got=%h exp=%h", bus.csr_rval, 32'(k)); end
      rd(14'h5);
      total++; if (bus.csr_rval[11] !== 1'b0 || bus.has_int !== 1'b0) begin
        bad++; $display("FAIL oneshot_early_int is11=%b has_int=%b exp=0", bus.csr_rval[11], bus.has_int);
      end
      tick();
    end
    rd(14'h5);
    total++; if (bus.csr_rval[11] !== 1'b1) begin bad++; $display("FAIL oneshot_fire got=%b exp=1", bus.csr_rval[11]); end
    total++; if (bus.has_int !== 1'b1) begin bad++; $display("FAIL oneshot_has_int got=%b exp=1", bus.has_int); end
    tick(); tick();
    rd(14'h42);
    total++; if (bus.csr_rval !== 32'hFFFF_FFFF) begin bad++; $display("FAIL oneshot_hold got=%h exp=ffffffff", bus.csr_rval); end
    wr(14'h44, 32'h1, 32'h1);
    rd(14'h5);
    total++; if (bus.csr_rval[11] !== 1'b0) begin bad++; $display("FAIL ticlr got=%b exp=0", bus.csr_rval[11]); end
    total++; if (bus.has_int !== 1'b0) begin bad++; $display("FAIL ticlr_has_int got=%b exp=0", bus.has_int); end
  endtask

  task automatic test_timer_periodic();
    do_reset();
    wr(14'h41, 32'h7, 32'hFFFF_FFFF);
    // clear every cycle: IS[11] is seen only right after a fire
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h44; bus.csr_wval = 32'h1; bus.csr_wmask = 32'h1;
    for (int k = 1; k <= 20; k++) begin
      rd(14'h42);
      total++; if (bus.csr_rval !== 32'(4 - ((k - 1) % 5))) begin
        bad++; $display("FAIL periodic_tval k=%0d got=%h exp=%h", k, bus.csr_rval, 32'(4 - ((k - 1) % 5)));
      end
      rd(14'h5);
      total++; if (bus.csr_rval[11] !== ((k > 1) && ((k - 1) % 5 == 0))) begin
        bad++; $display("FAIL periodic_is11 k=%0d got=%b", k, bus.csr_rval[11]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midcount();
    do_reset();
    wr(14'h41, 32'h7, 32'hFFFF_FFFF);
    repeat (6) tick();
    rd(14'h5);
    total++; if (bus.csr_rval[11] !== 1'b1) begin bad++; $display("FAIL midcount_fired got=%b exp=1", bus.csr_rval[11]); end
    do_reset();
    tick(); tick();
    rd(14'h42);
    total++; if (bus.csr_rval !== 32'h0) begin bad++; $display("FAIL midcount_tval got=%h exp=0", bus.csr_rval); end
    rd(14'h5);
    total++; if (bus.csr_rval !== 32'h0) begin bad++; $display("FAIL midcount_estat got=%h exp=0", bus.csr_rval); end
  endtask

  task automatic test_hw_int();
    do_reset();
    wr(14'h4, 32'h4, 32'hFFFF_FFFF);
    wr(14'h0, 32'h4, 32'h4);
    bus.hw_int_in = 8'h01;
    #1;
    total++; if (bus.has_int !== 1'b0) begin bad++; $display("FAIL hw_int_latency got=%b exp=0", bus.has_int); end
    tick();
    total++; if (bus.has_int !== 1'b1) begin bad++; $display("FAIL hw_int_seen got=%b exp=1", bus.has_int); end
    rd(14'h5);
    total++; if (bus.csr_rval !== 32'h4) begin bad++; $display("FAIL hw_int_estat got=%h exp=4", bus.csr_rval); end
    bus.hw_int_in = 8'h00;
    tick();
    total++; if (bus.has_int !== 1'b0) begin bad++; $display("FAIL hw_int_drop got=%b exp=0", bus.has_int); end
  endtask

  task automatic test_random();
    logic [13:0] a;
    logic [5:0]  codes [4] = '{6'h8, 6'h9, 6'hB, 6'h3};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      a = addrs[$urandom_range(0, 17)];
      bus.csr_we      = ($urandom_range(0, 1) == 1);
      bus.csr_wnum    = a;
      bus.csr_wmask   = $urandom;
      bus.csr_wval    = (a == 14'h41) ? 32'($urandom_range(0, 63)) : $urandom;
      bus.wb_exc      = ($urandom_range(0, 9) == 0);
      bus.wb_ecode    = codes[$urandom_range(0, 3)];
      bus.wb_esubcode = 9'($urandom_range(0, 1));
      bus.wb_pc       = $urandom;
      bus.wb_vaddr    = $urandom;
      bus.ertn_flush  = ($urandom_range(0, 9) == 0);
      bus.hw_int_in   = 8'($urandom_range(0, 255));
      bus.ipi_int_in  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 18; i++) begin
        rd(addrs[i]);
        total++; if (bus.csr_rval !== m_read(addrs[i])) begin
          bad++; $display("FAIL rand_read c=%0d addr=%h got=%h exp=%h", c, addrs[i], bus.csr_rval, m_read(addrs[i]));
        end
      end
      total++; if (bus.ex_entry !== m_eentry) begin bad++; $display("FAIL rand_ex_entry c=%0d got=%h exp=%h", c, bus.ex_entry, m_eentry); end
      total++; if (bus.ertn_pc !== m_era) begin bad++; $display("FAIL rand_ertn_pc c=%0d got=%h exp=%h", c, bus.ertn_pc, m_era); end
      total++; if (bus.has_int !== m_has_int()) begin bad++; $display("FAIL rand_has_int c=%0d got=%b exp=%b", c, bus.has_int, m_has_int()); end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_masked_write();
    test_exception();
    test_badv();
    test_timer_oneshot();
    test_timer_periodic();
    test_reset_midcount();
    test_hw_int();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
